// File: rtl/bp_fe_instr_realigner.sv
// Frontend instruction realigner: splits 32-bit fetch words into 16-bit parcels and
// reassembles instructions that straddle fetch-word boundaries, one per handshake.
module bp_fe_instr_realigner #(
    parameter int unsigned vaddr_width_p   = 39,
    parameter int unsigned instr_width_p   = 32,
    parameter int unsigned c_instr_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,

    input  logic                     fetch_v_i,
    input  logic [vaddr_width_p-1:0] fetch_pc_i,
    input  logic [instr_width_p-1:0] fetch_data_i,
    output logic                     fetch_yumi_o,

    output logic                     instr_v_o,
    output logic [vaddr_width_p-1:0] instr_pc_o,
    output logic [instr_width_p-1:0] instr_o,
    output logic                     is_compressed_o,
    input  logic                     instr_yumi_i
);

    typedef enum logic [1:0] {
        e_empty   = 2'd0,
        e_partial = 2'd1,
        e_pending = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [c_instr_width_p-1:0] hold_parcel_q, hold_parcel_d;
    logic [vaddr_width_p-1:0]   hold_pc_q, hold_pc_d;

    logic [c_instr_width_p-1:0] parcel0, parcel1;
    logic                       parcel0_c, parcel1_c;
    logic [vaddr_width_p-1:0]   upper_pc;

    assign parcel0   = fetch_data_i[c_instr_width_p-1:0];
    assign parcel1   = fetch_data_i[instr_width_p-1:c_instr_width_p];
    assign parcel0_c = (parcel0[1:0] != 2'b11);
    assign parcel1_c = (parcel1[1:0] != 2'b11);
    // PC of the upper parcel of the current fetch word
    assign upper_pc  = {fetch_pc_i[vaddr_width_p-1:2], 2'b10};

    always_comb begin
        state_d       = state_q;
        hold_parcel_d = hold_parcel_q;
        hold_pc_d     = hold_pc_q;
        instr_v_o     = 1'b0;
        instr_o       = '0;
        instr_pc_o    = '0;
        fetch_yumi_o  = 1'b0;

        if (reset_i || flush_i) begin
            state_d       = e_empty;
            hold_parcel_d = '0;
            hold_pc_d     = '0;
        end else begin
            unique case (state_q)
                e_pending: begin
                    instr_v_o  = 1'b1;
                    instr_o    = instr_width_p'(hold_parcel_q);
                    instr_pc_o = hold_pc_q;
                    if (instr_yumi_i) begin
                        state_d = e_empty;
                    end
                end

                e_partial: begin
                    if (fetch_v_i) begin
                        instr_v_o    = 1'b1;
                        instr_o      = {parcel0, hold_parcel_q};
                        instr_pc_o   = hold_pc_q;
                        fetch_yumi_o = instr_yumi_i;
                        if (instr_yumi_i) begin
                            hold_parcel_d = parcel1;
                            hold_pc_d     = upper_pc;
                            state_d       = parcel1_c ? e_pending : e_partial;
                        end
                    end
                end

                default: begin
                    if (fetch_v_i && !fetch_pc_i[1]) begin
                        instr_v_o    = 1'b1;
                        instr_pc_o   = fetch_pc_i;
                        fetch_yumi_o = instr_yumi_i;
                        if (!parcel0_c) begin
                            instr_o = fetch_data_i;
                        end else begin
                            instr_o = instr_width_p'(parcel0);
                            if (instr_yumi_i) begin
                                hold_parcel_d = parcel1;
                                hold_pc_d     = upper_pc;
                                state_d       = parcel1_c ? e_pending : e_partial;
                            end
                        end
                    end else if (fetch_v_i) begin
                        // Misaligned entry: only the upper parcel belongs to the stream
                        if (parcel1_c) begin
                            instr_v_o    = 1'b1;
                            instr_o      = instr_width_p'(parcel1);
                            instr_pc_o   = fetch_pc_i;
                            fetch_yumi_o = instr_yumi_i;
                        end else begin
                            fetch_yumi_o  = 1'b1;
                            hold_parcel_d = parcel1;
                            hold_pc_d     = fetch_pc_i;
                            state_d       = e_partial;
                        end
                    end
                end
            endcase
        end
    end

    assign is_compressed_o = instr_v_o & (instr_o[1:0] != 2'b11);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= e_empty;
            hold_parcel_q <= '0;
            hold_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            hold_parcel_q <= hold_parcel_d;
            hold_pc_q     <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_bp_fe_instr_realigner.sv
// Directed and randomized checks of bp_fe_instr_realigner against a parcel-stream
// reference model that decodes the instruction sequence from the fetched words.
module tb_bp_fe_instr_realigner;

    localparam int unsigned VW = 39;
    localparam int unsigned NW = 24;

    typedef struct {
        logic [31:0]   ins;
        logic [VW-1:0] pc;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          fetch_v_i = 1'b0;
    logic [VW-1:0] fetch_pc_i = '0;
    logic [31:0]   fetch_data_i = '0;
    logic          fetch_yumi_o;
    logic          instr_v_o;
    logic [VW-1:0] instr_pc_o;
    logic [31:0]   instr_o;
    logic          is_compressed_o;
    logic          instr_yumi_i = 1'b0;

    int checks = 0;
    int failures = 0;

    bp_fe_instr_realigner #(.vaddr_width_p(VW), .instr_width_p(32), .c_instr_width_p(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .fetch_v_i(fetch_v_i), .fetch_pc_i(fetch_pc_i), .fetch_data_i(fetch_data_i),
        .fetch_yumi_o(fetch_yumi_o),
        .instr_v_o(instr_v_o), .instr_pc_o(instr_pc_o), .instr_o(instr_o),
        .is_compressed_o(is_compressed_o), .instr_yumi_i(instr_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check the settled outputs.
    task automatic step(input string tag, input logic rst, input logic fl, input logic v,
                        input logic [VW-1:0] pc, input logic [31:0] data, input logic y,
                        input logic ev, input logic [31:0] ei, input logic [VW-1:0] epc,
                        input logic efy);
        @(negedge clk_i);
        reset_i = rst; flush_i = fl; fetch_v_i = v; fetch_pc_i = pc;
        fetch_data_i = data; instr_yumi_i = y;
        #1;
        chk({tag, "_v"}, 64'(instr_v_o), 64'(ev));
        chk({tag, "_fy"}, 64'(fetch_yumi_o), 64'(efy));
        if (ev) begin
            chk({tag, "_instr"}, 64'(instr_o), 64'(ei));
            chk({tag, "_pc"}, 64'(instr_pc_o), 64'(epc));
            chk({tag, "_c"}, 64'(is_compressed_o), 64'(ei[1:0] != 2'b11));
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [15:0] rand_parcel();
        logic [15:0] p;
        p = 16'($urandom);
        if ($urandom_range(0, 1) == 1) p[1:0] = 2'($urandom_range(0, 2));
        else p[1:0] = 2'b11;
        return p;
    endfunction

    // Random stream of sequential words starting at base (+2 if misaligned).
    task automatic rand_round(input string tag, input logic [VW-1:0] base, input logic mis);
        logic [15:0]   par [2*NW];
        logic [31:0]   wd [NW];
        exp_t          q[$];
        exp_t          e;
        int            i, k, cycles;
        logic          present, prev_hold;
        logic [31:0]   prev_instr;
        logic [VW-1:0] prev_pc, start_pc;

        for (int w = 0; w < int'(NW); w++) begin
            par[2*w]   = rand_parcel();
            par[2*w+1] = rand_parcel();
            wd[w]      = {par[2*w+1], par[2*w]};
        end
        // Reference: walk the parcel stream, pairing each uncompressed parcel with its successor
        i = mis ? 1 : 0;
        while (i < int'(2*NW)) begin
            e.pc = base + VW'(2*i);
            if (par[i][1:0] != 2'b11) begin
                e.ins = {16'h0, par[i]};
                q.push_back(e);
                i++;
            end else if (i + 1 < int'(2*NW)) begin
                e.ins = {par[i+1], par[i]};
                q.push_back(e);
                i += 2;
            end else begin
                break;
            end
        end

        start_pc = mis ? base + VW'(2) : base;
        k = 0; cycles = 0; present = 1'b0; prev_hold = 1'b0;
        prev_instr = '0; prev_pc = '0;
        while ((k < int'(NW) || q.size() != 0) && cycles < 3000) begin
            @(negedge clk_i);
            cycles++;
            if (!present && k < int'(NW)) present = ($urandom_range(0, 3) != 0);
            reset_i = 1'b0; flush_i = 1'b0;
            fetch_v_i    = present;
            fetch_pc_i   = (k == 0) ? start_pc : base + VW'(4*k);
            fetch_data_i = (k < int'(NW)) ? wd[k] : 32'h0;
            instr_yumi_i = ($urandom_range(0, 2) != 0);
            #1;
            chk({tag, "_fy_without_v"}, 64'(fetch_yumi_o & ~fetch_v_i), 64'(0));
            if (prev_hold) begin
                chk({tag, "_stall_v"}, 64'(instr_v_o), 64'(1));
                chk({tag, "_stall_instr"}, 64'(instr_o), 64'(prev_instr));
                chk({tag, "_stall_pc"}, 64'(instr_pc_o), 64'(prev_pc));
            end
            if (instr_v_o && instr_yumi_i) begin
                chk({tag, "_q_nonempty"}, 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk({tag, "_instr"}, 64'(instr_o), 64'(e.ins));
                    chk({tag, "_pc"}, 64'(instr_pc_o), 64'(e.pc));
                    chk({tag, "_c"}, 64'(is_compressed_o), 64'(e.ins[1:0] != 2'b11));
                end
            end
            prev_hold  = instr_v_o && !instr_yumi_i;
            prev_instr = instr_o;
            prev_pc    = instr_pc_o;
            if (fetch_yumi_o) begin
                k++;
                present = 1'b0;
            end
        end
        chk({tag, "_words_consumed"}, 64'(k), 64'(NW));
        chk({tag, "_stream_drained"}, 64'(q.size()), 64'(0));
        step({tag, "_flush"}, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle({tag, "_after_flush"});
    endtask

    initial begin
        // Reset, with a fetch word presented that must be ignored
        step("reset0", 1'b1, 1'b0, 1'b1, 39'h80000000, 32'h00a00093, 1'b1, 1'b0, '0, '0, 1'b0);
        step("reset1", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle("idle0");
        chk("idle0_instr_zero", 64'(instr_o), 64'(0));
        chk("idle0_pc_zero", 64'(instr_pc_o), 64'(0));

        step("aligned32", 1'b0, 1'b0, 1'b1, 39'h80000000, 32'h00a00093, 1'b1, 1'b1, 32'h00a00093, 39'h80000000, 1'b1);
        idle("aligned32_idle");

        step("cc_first", 1'b0, 1'b0, 1'b1, 39'h80000000, 32'h45050001, 1'b1, 1'b1, 32'h00000001, 39'h80000000, 1'b1);
        step("cc_second", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h00004505, 39'h80000002, 1'b0);
        idle("cc_idle");

        step("str_first", 1'b0, 1'b0, 1'b1, 39'h80000000, 32'h00930001, 1'b1, 1'b1, 32'h00000001, 39'h80000000, 1'b1);
        step("str_join", 1'b0, 1'b0, 1'b1, 39'h80000004, 32'h450500a0, 1'b1, 1'b1, 32'h00a00093, 39'h80000002, 1'b1);
        step("str_pend", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h00004505, 39'h80000006, 1'b0);
        idle("str_idle");

        step("mis_hold", 1'b0, 1'b0, 1'b1, 39'h80000002, 32'h0093abcd, 1'b0, 1'b0, '0, '0, 1'b1);
        step("mis_join", 1'b0, 1'b0, 1'b1, 39'h80000004, 32'h000000a0, 1'b1, 1'b1, 32'h00a00093, 39'h80000002, 1'b1);
        step("mis_pend", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h00000000, 39'h80000006, 1'b0);
        idle("mis_idle");

        step("fl_hold", 1'b0, 1'b0, 1'b1, 39'h80000002, 32'h0093abcd, 1'b1, 1'b0, '0, '0, 1'b1);
        step("fl_flush", 1'b0, 1'b1, 1'b1, 39'h80000004, 32'h000000a0, 1'b1, 1'b0, '0, '0, 1'b0);
        step("fl_after", 1'b0, 1'b0, 1'b1, 39'h80001000, 32'h00a00093, 1'b1, 1'b1, 32'h00a00093, 39'h80001000, 1'b1);
        idle("fl_idle");

        for (int c = 0; c < 3; c++)
            step("bp_stall", 1'b0, 1'b0, 1'b1, 39'h80000000, 32'h45050001, 1'b0, 1'b1, 32'h00000001, 39'h80000000, 1'b0);
        step("bp_accept", 1'b0, 1'b0, 1'b1, 39'h80000000, 32'h45050001, 1'b1, 1'b1, 32'h00000001, 39'h80000000, 1'b1);
        step("bp_pend", 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h00004505, 39'h80000002, 1'b0);
        step("bp_reset", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle("bp_after_reset");

        rand_round("rand_wrap", 39'h7FFFFFFFF8, 1'b0);
        rand_round("rand_mis", {7'($urandom), 30'($urandom), 2'b00}, 1'b1);
        rand_round("rand_al", {7'($urandom), 30'($urandom), 2'b00}, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
